// File: rtl/write_fifo_drain_if.sv
// FIFO read port and Avalon-MM write master bundle
// for the write FIFO drain stage.
interface write_fifo_drain_if #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32
);
  logic                  FF_readrequest;
  logic [DATA_W-1:0]     FF_q;
  logic                  FF_empty;
  logic [ADDR_W-1:0]     avm_address;
  logic [DATA_W-1:0]     avm_writedata;
  logic [DATA_W/8-1:0]   avm_byteenable;
  logic                  avm_write;
  logic                  avm_waitrequest;

  modport master (
    output FF_readrequest,
    input  FF_q,
    input  FF_empty,
    output avm_address,
    output avm_writedata,
    output avm_byteenable,
    output avm_write,
    input  avm_waitrequest
  );

  modport slave (
    input  FF_readrequest,
    output FF_q,
    output FF_empty,
    input  avm_address,
    input  avm_writedata,
    input  avm_byteenable,
    input  avm_write,
    output avm_waitrequest
  );
endinterface

// File: rtl/write_fifo_drain.sv
// Drains {address, data} word pairs from the shared write FIFO
// and issues one Avalon-MM write per pair.
module write_fifo_drain #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  write_fifo_drain_if.master bus,
  output logic [CNT_W-1:0] wr_count,
  output logic             idle,
  output logic             addr_err
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ADDR,
    RD_DATA,
    WAIT_DATA,
    WRITE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                rd;

  // State and datapath registers, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state, capture and FIFO pop decode
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rd      = 1'b0;
    unique case (state_q)
      IDLE: begin
        rd = !bus.FF_empty;
        if (!bus.FF_empty) state_d = WAIT_ADDR;
      end
      WAIT_ADDR: begin
        addr_d = bus.FF_q[ADDR_W-1:0];
        if (|bus.FF_q[DATA_W-1:ADDR_W]) err_d = 1'b1;
        state_d = RD_DATA;
      end
      RD_DATA: begin
        rd = !bus.FF_empty;
        if (!bus.FF_empty) state_d = WAIT_DATA;
      end
      WAIT_DATA: begin
        data_d  = bus.FF_q;
        state_d = WRITE;
      end
      WRITE: begin
        if (!bus.avm_waitrequest) begin
          cnt_d   = cnt_q + CNT_W'(1);
          rd      = !bus.FF_empty;
          state_d = bus.FF_empty ? IDLE : WAIT_ADDR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.FF_readrequest = rd && !rst;
  assign bus.avm_address    = addr_q;
  assign bus.avm_writedata  = data_q;
  assign bus.avm_write      = (state_q == WRITE);
  assign bus.avm_byteenable = bus.avm_write ? '1 : '0;
  assign wr_count           = cnt_q;
  assign addr_err           = err_q;
  assign idle               = (state_q == IDLE) && bus.FF_empty;

endmodule

// File: tb/tb_write_fifo_drain.sv
// Bench for write_fifo_drain: behavioural FIFO, stalling Avalon slave
// and a scoreboard of expected writes.
module tb_write_fifo_drain;
  localparam int AW = 23;
  localparam int DW = 32;
  localparam int CW = 32;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } pair_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] wr_count;
  logic          idle;
  logic          addr_err;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;

  int n_cmp = 0;
  int n_err = 0;
  int viol  = 0;

  logic [DW-1:0] fifo[$];
  logic [DW-1:0] pre[$];
  pair_t         exp_q[$];

  write_fifo_drain_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  write_fifo_drain #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .CNT_W (CW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .wr_count(wr_count),
    .idle    (idle),
    .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  // normal-mode FIFO: data one cycle after pop, empty updates after write
  always @(posedge clk) begin
    if (bus.FF_readrequest && fifo.size() > 0)
      bus.FF_q <= fifo.pop_front();
    if (wr_en) fifo.push_back(wr_data);
    bus.FF_empty <= (fifo.size() == 0);
  end

  // scoreboard of accepted writes plus pop-protocol watch
  always @(negedge clk) begin
    pair_t e;
    #2;
    if (bus.FF_readrequest && bus.FF_empty) viol++;
    if (bus.FF_readrequest && bus.avm_write && bus.avm_waitrequest)
      viol++;
    if (bus.avm_write && !bus.avm_waitrequest && !rst) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected got addr=%h data=%h exp none",
                 bus.avm_address, bus.avm_writedata);
      end else begin
        e = exp_q.pop_front();
        if ({bus.avm_address, bus.avm_writedata, bus.avm_byteenable}
            !== {e.a, e.d, 4'hF}) begin
          n_err++;
          $display("FAIL sb_write got %h/%h/%h exp %h/%h/f",
                   bus.avm_address, bus.avm_writedata,
                   bus.avm_byteenable, e.a, e.d);
        end
      end
    end
  end

  task automatic fifo_put(input logic [DW-1:0] w);
    wr_en   = 1'b1;
    wr_data = w;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  // hold reset, load pre[] into the FIFO, release: returns in cycle 0
  task automatic preload();
    rst = 1'b1;
    @(negedge clk);
    foreach (pre[i]) fifo_put(pre[i]);
    pre.delete();
    #1;
    n_cmp++;
    if (bus.FF_readrequest !== 1'b0) begin
      n_err++;
      $display("FAIL rd_in_reset got %b exp 0", bus.FF_readrequest);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.FF_readrequest !== 1'b1) begin
      n_err++;
      $display("FAIL rd_cycle0 got %b exp 1", bus.FF_readrequest);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.avm_waitrequest = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({bus.avm_write, bus.avm_byteenable, bus.FF_readrequest}
        !== 6'b0) begin
      n_err++;
      $display("FAIL rst_ctrl got %b%h%b exp 0_0_0", bus.avm_write,
               bus.avm_byteenable, bus.FF_readrequest);
    end
    n_cmp++;
    if ({bus.avm_address, bus.avm_writedata} !== '0) begin
      n_err++;
      $display("FAIL rst_bus got %h/%h exp 0/0",
               bus.avm_address, bus.avm_writedata);
    end
    n_cmp++;
    if ({wr_count, addr_err, idle} !== {32'd0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL rst_status got cnt=%0d err=%b idle=%b exp 0/0/1",
               wr_count, addr_err, idle);
    end
  endtask

  task automatic test_single();
    logic [1:0] ex;
    bus.avm_waitrequest = 1'b0;
    pre = '{32'h0000_1234, 32'hDEAD_BEEF};
    exp_q.push_back('{a: 23'h001234, d: 32'hDEAD_BEEF});
    preload();
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      #1;
      ex = {c == 2, c == 4};
      n_cmp++;
      if ({bus.FF_readrequest, bus.avm_write} !== ex) begin
        n_err++;
        $display("FAIL single_c%0d rd/wr got %b%b exp %b", c,
                 bus.FF_readrequest, bus.avm_write, ex);
      end
      if (c == 4) begin
        n_cmp++;
        if ({bus.avm_address, bus.avm_writedata, bus.avm_byteenable}
            !== {23'h001234, 32'hDEAD_BEEF, 4'hF}) begin
          n_err++;
          $display("FAIL single_bus got %h/%h/%h exp 001234/deadbeef/f",
                   bus.avm_address, bus.avm_writedata,
                   bus.avm_byteenable);
        end
      end
    end
    n_cmp++;
    if ({wr_count, idle, exp_q.size() == 0}
        !== {32'd1, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL single_end got cnt=%0d idle=%b left=%0d exp 1/1/0",
               wr_count, idle, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] ex;
    bus.avm_waitrequest = 1'b1;
    pre = '{32'h0000_1234, 32'hDEAD_BEEF, 32'h0000_4321, 32'h0BAD_F00D};
    exp_q.push_back('{a: 23'h001234, d: 32'hDEAD_BEEF});
    exp_q.push_back('{a: 23'h004321, d: 32'h0BAD_F00D});
    preload();
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 7) bus.avm_waitrequest = 1'b0;
      #1;
      ex = {c == 2 || c == 7 || c == 9,
            (c >= 4 && c <= 7) || c == 11};
      n_cmp++;
      if ({bus.FF_readrequest, bus.avm_write} !== ex) begin
        n_err++;
        $display("FAIL bp_c%0d rd/wr got %b%b exp %b", c,
                 bus.FF_readrequest, bus.avm_write, ex);
      end
      if (c >= 4 && c <= 7) begin
        n_cmp++;
        if ({bus.avm_address, bus.avm_writedata}
            !== {23'h001234, 32'hDEAD_BEEF}) begin
          n_err++;
          $display("FAIL bp_hold_c%0d got %h/%h exp 001234/deadbeef",
                   c, bus.avm_address, bus.avm_writedata);
        end
      end
      if (c == 8 || c == 12) begin
        n_cmp++;
        if (wr_count !== ((c == 8) ? 32'd1 : 32'd2)) begin
          n_err++;
          $display("FAIL bp_cnt_c%0d got %0d exp %0d", c, wr_count,
                   (c == 8) ? 1 : 2);
        end
      end
    end
  endtask

  task automatic test_streaming();
    logic [1:0] ex;
    bus.avm_waitrequest = 1'b0;
    pre = '{32'h0000_0010, 32'hA0A0_0001,
            32'h0000_0020, 32'hB0B0_0002,
            32'h007F_FFFF, 32'hC0C0_0003};
    exp_q.push_back('{a: 23'h000010, d: 32'hA0A0_0001});
    exp_q.push_back('{a: 23'h000020, d: 32'hB0B0_0002});
    exp_q.push_back('{a: 23'h7FFFFF, d: 32'hC0C0_0003});
    preload();
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      #1;
      ex = {(c % 2 == 0) && c <= 10, c == 4 || c == 8 || c == 12};
      n_cmp++;
      if ({bus.FF_readrequest, bus.avm_write} !== ex) begin
        n_err++;
        $display("FAIL stream_c%0d rd/wr got %b%b exp %b", c,
                 bus.FF_readrequest, bus.avm_write, ex);
      end
    end
    n_cmp++;
    if ({wr_count, idle, addr_err, exp_q.size() == 0}
        !== {32'd3, 1'b1, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL stream_end got cnt=%0d idle=%b err=%b left=%0d exp 3/1/0/0",
               wr_count, idle, addr_err, exp_q.size());
    end
  endtask

  task automatic test_split();
    logic [1:0] ex;
    bus.avm_waitrequest = 1'b0;
    exp_q.push_back('{a: 23'h000ABC, d: 32'h1357_9BDF});
    fifo_put(32'h0000_0ABC);
    #1;
    n_cmp++;
    if (bus.FF_readrequest !== 1'b1) begin
      n_err++;
      $display("FAIL split_pop_addr got %b exp 1", bus.FF_readrequest);
    end
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if ({bus.FF_readrequest, bus.avm_write, idle} !== 3'b000) begin
        n_err++;
        $display("FAIL split_wait_c%0d rd/wr/idle got %b%b%b exp 000", c,
                 bus.FF_readrequest, bus.avm_write, idle);
      end
    end
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = 32'h1357_9BDF;
    for (int d = 1; d <= 4; d++) begin
      @(negedge clk);
      wr_en = 1'b0;
      #1;
      ex = {d == 1, d == 3};
      n_cmp++;
      if ({bus.FF_readrequest, bus.avm_write} !== ex) begin
        n_err++;
        $display("FAIL split_d%0d rd/wr got %b%b exp %b", d,
                 bus.FF_readrequest, bus.avm_write, ex);
      end
    end
    n_cmp++;
    if ({wr_count, idle, exp_q.size() == 0}
        !== {32'd4, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL split_end got cnt=%0d idle=%b left=%0d exp 4/1/0",
               wr_count, idle, exp_q.size());
    end
  endtask

  task automatic test_addr_err();
    bus.avm_waitrequest = 1'b0;
    exp_q.push_back('{a: 23'h000005, d: 32'h1111_2222});
    fifo_put(32'h0080_0005);
    fifo_put(32'h1111_2222);
    #1;
    n_cmp++;
    if (addr_err !== 1'b0) begin
      n_err++;
      $display("FAIL aerr_before got %b exp 0", addr_err);
    end
    for (int c = 2; c <= 6; c++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if ({addr_err, bus.avm_address} !== {1'b1, 23'h000005}) begin
        n_err++;
        $display("FAIL aerr_c%0d got err=%b addr=%h exp 1/000005", c,
                 addr_err, bus.avm_address);
      end
      if (c == 4) begin
        n_cmp++;
        if (bus.avm_write !== 1'b1) begin
          n_err++;
          $display("FAIL aerr_write got %b exp 1", bus.avm_write);
        end
      end
    end
    n_cmp++;
    if ({wr_count, exp_q.size() == 0} !== {32'd5, 1'b1}) begin
      n_err++;
      $display("FAIL aerr_end got cnt=%0d left=%0d exp 5/0",
               wr_count, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_write();
    int k;
    bus.avm_waitrequest = 1'b1;
    fifo_put(32'h0000_0777);
    fifo_put(32'h5555_AAAA);
    for (int c = 2; c <= 4; c++) @(negedge clk);
    #1;
    n_cmp++;
    if ({bus.avm_write, addr_err, wr_count}
        !== {1'b1, 1'b1, 32'd5}) begin
      n_err++;
      $display("FAIL rmw_pre got wr=%b err=%b cnt=%0d exp 1/1/5",
               bus.avm_write, addr_err, wr_count);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.avm_write, bus.FF_readrequest} !== 2'b10) begin
      n_err++;
      $display("FAIL rmw_in_rst got wr/rd %b%b exp 10",
               bus.avm_write, bus.FF_readrequest);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.avm_waitrequest = 1'b0;
    #1;
    n_cmp++;
    if ({bus.avm_write, wr_count, addr_err, idle}
        !== {1'b0, 32'd0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL rmw_after got wr=%b cnt=%0d err=%b idle=%b exp 0/0/0/1",
               bus.avm_write, wr_count, addr_err, idle);
    end
    n_cmp++;
    if ({bus.avm_address, bus.avm_writedata} !== '0) begin
      n_err++;
      $display("FAIL rmw_bus got %h/%h exp 0/0",
               bus.avm_address, bus.avm_writedata);
    end
    exp_q.push_back('{a: 23'h0002AB, d: 32'hCAFE_0001});
    fifo_put(32'h0000_02AB);
    fifo_put(32'hCAFE_0001);
    k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      @(negedge clk);
      #3;
      k++;
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({exp_q.size() == 0, wr_count, addr_err}
        !== {1'b1, 32'd1, 1'b0}) begin
      n_err++;
      $display("FAIL rmw_next got left=%0d cnt=%0d err=%b exp 0/1/0",
               exp_q.size(), wr_count, addr_err);
    end
  endtask

  initial begin
    bus.avm_waitrequest = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_streaming();
    test_split();
    test_addr_err();
    test_reset_mid_write();
    n_cmp++;
    if (viol !== 0) begin
      n_err++;
      $display("FAIL pop_protocol got %0d bad pops exp 0", viol);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
